// File: rtl/fpu_pkg.sv
// Shared FPU definitions: funct5 opcodes, execution-unit ids and dispatcher FSM states.
package fpu_pkg;

  localparam logic [4:0] FPU_ADD        = 5'b00000;
  localparam logic [4:0] FPU_SUB        = 5'b00001;
  localparam logic [4:0] FPU_MUL        = 5'b00010;
  localparam logic [4:0] FPU_DIV        = 5'b00011;
  localparam logic [4:0] FPU_SGNJ       = 5'b00100;
  localparam logic [4:0] FPU_MINMAX     = 5'b00101;
  localparam logic [4:0] FPU_SQRT       = 5'b01011;
  localparam logic [4:0] FPU_CMP        = 5'b10100;
  localparam logic [4:0] FPU_CVT_F2I    = 5'b11000;
  localparam logic [4:0] FPU_CVT_I2F    = 5'b11010;
  localparam logic [4:0] FPU_CLASS_MVXW = 5'b11100;
  localparam logic [4:0] FPU_MVWX       = 5'b11110;

  localparam logic [1:0] UNIT_NONE = 2'd0;
  localparam logic [1:0] UNIT_MUL  = 2'd1;
  localparam logic [1:0] UNIT_DIV  = 2'd2;
  localparam logic [1:0] UNIT_SQRT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_op_dispatch_if.sv
// Request, execution-unit and response signals between the FPU dispatcher and its environment.
// The slave modport is the dispatcher; master is the issuing pipeline plus the execution units.
interface fpu_op_dispatch_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_funct5;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [2:0]  req_rm;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_rm;
  logic [4:0]  sel;

  logic        mul_start;
  logic        div_start;
  logic        sqrt_start;
  logic        mul_done;
  logic        div_done;
  logic        sqrt_done;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_illegal;
  logic        resp_timeout;

  modport master (
    output req_valid, req_funct5, req_rs1, req_rs2, req_rm,
    output mul_done, div_done, sqrt_done, resp_ready,
    input  req_ready, op_a, op_b, op_rm, sel,
    input  mul_start, div_start, sqrt_start,
    input  resp_valid, resp_illegal, resp_timeout
  );

  modport slave (
    input  req_valid, req_funct5, req_rs1, req_rs2, req_rm,
    input  mul_done, div_done, sqrt_done, resp_ready,
    output req_ready, op_a, op_b, op_rm, sel,
    output mul_start, div_start, sqrt_start,
    output resp_valid, resp_illegal, resp_timeout
  );

endinterface

// File: rtl/fpu_op_decode.sv
// Combinational funct5 classifier: legality, single/multi-cycle and which multi-cycle unit runs it.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [4:0] funct5_i,
  output logic       legal_o,
  output logic       is_multi_o,
  output logic [1:0] unit_id_o
);

  always_comb begin
    legal_o    = 1'b1;
    is_multi_o = 1'b0;
    unit_id_o  = UNIT_NONE;
    case (funct5_i)
      FPU_MUL: begin
        is_multi_o = 1'b1;
        unit_id_o  = UNIT_MUL;
      end
      FPU_DIV: begin
        is_multi_o = 1'b1;
        unit_id_o  = UNIT_DIV;
      end
      FPU_SQRT: begin
        is_multi_o = 1'b1;
        unit_id_o  = UNIT_SQRT;
      end
      FPU_ADD, FPU_SUB, FPU_SGNJ, FPU_MINMAX, FPU_CMP,
      FPU_CVT_F2I, FPU_CVT_I2F, FPU_CLASS_MVXW, FPU_MVWX: begin
        legal_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_op_dispatch.sv
// FPU issue controller: latches one op, pulses the multi-cycle unit start, guards completion with a
// timeout and holds sel/operands/flags with resp_valid until resp_ready. Single-cycle ops respond in 1 cycle.
module fpu_op_dispatch
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  fpu_op_dispatch_if.slave disp_io
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    unit_q, unit_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [2:0]    op_rm_q, op_rm_d;
  logic [4:0]    sel_q, sel_d;
  logic [2:0]    start_q, start_d;   // {mul, div, sqrt}
  logic          resp_valid_q, resp_valid_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;

  logic          dec_legal;
  logic          dec_multi;
  logic [1:0]    dec_unit;
  logic          unit_done;

  fpu_op_decode u_decode (
    .funct5_i   (disp_io.req_funct5),
    .legal_o    (dec_legal),
    .is_multi_o (dec_multi),
    .unit_id_o  (dec_unit)
  );

  // Only the unit actually issued may complete the op; other done pulses are noise.
  always_comb begin
    unit_done = 1'b0;
    case (unit_q)
      UNIT_MUL:  unit_done = disp_io.mul_done;
      UNIT_DIV:  unit_done = disp_io.div_done;
      UNIT_SQRT: unit_done = disp_io.sqrt_done;
      default:   unit_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    unit_d       = unit_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_rm_d      = op_rm_q;
    sel_d        = sel_q;
    start_d      = 3'b000;
    resp_valid_d = resp_valid_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (disp_io.req_valid) begin
          op_a_d  = disp_io.req_rs1;
          op_b_d  = disp_io.req_rs2;
          op_rm_d = disp_io.req_rm;
          sel_d   = disp_io.req_funct5;
          if (!dec_legal) begin
            sel_d        = 5'b00000;
            illegal_d    = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else if (dec_multi) begin
            unit_d = dec_unit;
            case (dec_unit)
              UNIT_MUL:  start_d = 3'b100;
              UNIT_DIV:  start_d = 3'b010;
              UNIT_SQRT: start_d = 3'b001;
              default:   start_d = 3'b000;
            endcase
            state_d = S_ISSUE;
          end else begin
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done arriving on the last counted cycle still completes normally.
        if (unit_done) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d    = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (disp_io.resp_ready) begin
          resp_valid_d = 1'b0;
          illegal_d    = 1'b0;
          timeout_d    = 1'b0;
          unit_d       = UNIT_NONE;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      unit_q       <= UNIT_NONE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_rm_q      <= '0;
      sel_q        <= '0;
      start_q      <= '0;
      resp_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      unit_q       <= unit_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_rm_q      <= op_rm_d;
      sel_q        <= sel_d;
      start_q      <= start_d;
      resp_valid_q <= resp_valid_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
    end
  end

  assign disp_io.req_ready    = (state_q == S_IDLE);
  assign disp_io.op_a         = op_a_q;
  assign disp_io.op_b         = op_b_q;
  assign disp_io.op_rm        = op_rm_q;
  assign disp_io.sel          = sel_q;
  assign disp_io.mul_start    = start_q[2];
  assign disp_io.div_start    = start_q[1];
  assign disp_io.sqrt_start   = start_q[0];
  assign disp_io.resp_valid   = resp_valid_q;
  assign disp_io.resp_illegal = illegal_q;
  assign disp_io.resp_timeout = timeout_q;

endmodule

// File: doc/fpu_op_dispatch.md
# fpu_op_dispatch

Issue-side controller of the FPU datapath. Accepts one FP operation at a time (funct5 plus two operands and rounding mode), registers the operands toward the execution units, and pulses the start of the multi-cycle units (mul, div, sqrt). It tracks completion with a timeout guard and holds the 5-bit result-mux select stable until the response is accepted. It is the control counterpart of the FPU result-selection mux: it produces `sel` and the response valid that the mux's `Result`/`OverFlow` are qualified by.

## Interface
- `TIMEOUT`, 64: max cycles in WAIT before a forced timeout response (≥2).
- `clk  in  1  clock`; single clock domain.
- `rst  in  1  reset`; asynchronous and active-high.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: dispatcher idle, can accept.
- `req_funct5  in  5`: operation code.
- `req_rs1, req_rs2  in  32 each`: operands.
- `req_rm  in  3`: rounding mode.
- `op_a, op_b  out  32 each`: registered operands to all units.
- `op_rm  out  3`: registered rounding mode.
- `sel  out  5`: result-mux select, registered.
- `mul_start, div_start, sqrt_start  out  1 each`: one-cycle start pulses.
- `mul_done, div_done, sqrt_done  in  1 each`: unit completion pulses.
- `resp_valid  out  1`: result at mux output is valid.
- `resp_ready  in  1`: consumer accepts.
- `resp_illegal  out  1`: funct5 not supported.
- `resp_timeout  out  1`: unit failed to complete within TIMEOUT.

## Operation
- Supported funct5 values:
  - Single-cycle: 00000, 00001, 00100, 00101, 10100, 11000, 11010, 11100, 11110.
  - Multi-cycle: 00010 (mul), 00011 (div), 01011 (sqrt).
- FSM states:
  - IDLE: `req_ready=1`. When `req_valid`, latch rs1/rs2/rm/funct5 into op_a/op_b/op_rm/sel.
    - Multi-cycle op -> ISSUE.
    - Single-cycle op -> RESP.
    - Illegal op -> RESP with `resp_illegal=1` and `sel` forced to 00000.
  - ISSUE: the matching `*_start` is high for exactly this cycle; clear the timeout counter; go to WAIT. Done inputs are ignored in ISSUE.
  - WAIT: increment the counter each cycle.
    - Done of the issued unit -> RESP.
    - Counter reaching TIMEOUT-1 without done -> RESP with `resp_timeout=1`.
    - Done in the same cycle as the timeout wins: no timeout is flagged.
    - Done of a non-issued unit is ignored.
  - RESP: `resp_valid=1`; hold `sel`, operands and flags. On `resp_ready`, clear the flags and go to IDLE.
- No new request is accepted in the RESP cycle; back-to-back throughput is one op per two cycles at best.
- Stray done pulses in IDLE or RESP are ignored.

## Timing
- All outputs are registered except `req_ready`, which is decoded from state.
- Reset values:
  - state IDLE, `req_ready=1`.
  - op_a, op_b, op_rm, sel = 0.
  - All `*_start` = 0, `resp_valid=0`, `resp_illegal=0`, `resp_timeout=0`.
- Single-cycle op: accepted at edge N; `resp_valid` high from cycle N+1.
- Multi-cycle op:
  - accepted at edge N; start high in cycle N+1;
  - done sampled in cycle N+1+k (k≥1); `resp_valid` high in cycle N+2+k.
- Timeout: `resp_valid` with `resp_timeout` asserted at cycle N+2+TIMEOUT.
- `resp_valid` stays high until the `resp_ready` edge, with no combinational dependency on `resp_ready`.
- Reset asserted mid-operation:
  - immediate return to reset values;
  - a start pulse in flight is cut;
  - a later done from an aborted unit is ignored.

## Structure
- Shared package `fpu_pkg`:
  - funct5 localparams: FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_SGNJ, FPU_MINMAX, FPU_SQRT, FPU_CMP, FPU_CLASS_MVXW, FPU_MVWX, FPU_CVT_I2F, FPU_CVT_F2I;
  - the FSM state encoding.
- One combinational sub-module, `fpu_op_decode`: funct5 -> {legal, is_multi, unit_id[1:0]}.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- Reset release, then req funct5=00000, rs1=0x3F800000, rs2=0x40000000:
  - `req_ready` drops the next cycle;
  - `resp_valid` at N+1 with sel=00000, op_a=0x3F800000;
  - no start pulses.
- funct5=00011 with div_done returned 5 cycles after div_start, `resp_ready` held low 3 cycles:
  - a single one-cycle `div_start` pulse;
  - `resp_valid` at N+7, held 3 cycles, sel=00011 stable throughout.
- funct5=01011 with sqrt_done never asserted, TIMEOUT=8:
  - `resp_valid` and `resp_timeout`=1 at N+10;
  - after handshake, IDLE with flags cleared.
- funct5=00111 (illegal):
  - `resp_valid` at N+1 with `resp_illegal=1`, sel=00000;
  - no start pulses.
- mul op in WAIT, then a stray div_done pulse, then `rst` asserted for 1 cycle before mul_done:
  - div_done is ignored;
  - all outputs return to reset values asynchronously;
  - a later mul_done produces no response.
- funct5=00010 with mul_done in the same cycle the counter reaches TIMEOUT-1: `resp_timeout=0`.
